alu_issue_stage: RTL and testbench

Producer side of the alu32 operand/control interface. Accepts RV32I instructions and register-file operands through a valid/ready handshake, then decodes the 4-bit ALU control. Selects operand_a/operand_b (register, immediate, PC or zero) and presents them registered to the ALU stage through a second valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_op_decode.sv | 80 ++++++++
 rtl/alu_issue_stage.sv | 95 +++++++++
 tb/tb_alu_issue_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control, opcode and funct constants plus the issue entry type
package alu_pkg;

  localparam int XLEN_P = 32;

  localparam logic [3:0] CTL_ADD  = 4'b0000;
  localparam logic [3:0] CTL_SUB  = 4'b0001;
  localparam logic [3:0] CTL_AND  = 4'b0010;
  localparam logic [3:0] CTL_OR   = 4'b0100;
  localparam logic [3:0] CTL_XOR  = 4'b0110;
  localparam logic [3:0] CTL_SLL  = 4'b1000;
  localparam logic [3:0] CTL_SRL  = 4'b1010;
  localparam logic [3:0] CTL_SLT  = 4'b1100;
  localparam logic [3:0] CTL_SLTU = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]        control;
    logic [XLEN_P-1:0] operand_a;
    logic [XLEN_P-1:0] operand_b;
    logic [4:0]        rd;
    logic              illegal;
  } issue_entry_t;

  // funct3 to control for the base (funct7 = 0) encodings shared by OP and OP-IMM
  function automatic logic [3:0] f3_to_control(input logic [2:0] f3);
    logic [3:0] ctl;
    case (f3)
      F3_ADD:  ctl = CTL_ADD;
      F3_SLL:  ctl = CTL_SLL;
      F3_SLT:  ctl = CTL_SLT;
      F3_SLTU: ctl = CTL_SLTU;
      F3_XOR:  ctl = CTL_XOR;
      F3_SRL:  ctl = CTL_SRL;
      F3_OR:   ctl = CTL_OR;
      default: ctl = CTL_AND;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I decode to ALU control and operand selection
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  output logic [3:0]      control,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [4:0]      rd,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [3:0]      w_ctl;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_legal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  always_comb begin
    w_ctl   = CTL_ADD;
    w_a     = '0;
    w_b     = '0;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_a   = rs1_data;
        w_b   = rs2_data;
        w_ctl = f3_to_control(w_funct3);
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
        end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
          w_legal = 1'b1;
          w_ctl   = CTL_SUB;
        end
      end
      OPC_OP_IMM: begin
        w_a   = rs1_data;
        w_ctl = f3_to_control(w_funct3);
        // shifts carry a 5-bit shamt; the upper immediate bits act as funct7
        if (w_funct3 == F3_SLL || w_funct3 == F3_SRL) begin
          w_b     = {{(XLEN-5){1'b0}}, instr[24:20]};
          w_legal = (w_funct7 == F7_BASE);
        end else begin
          w_b     = {{(XLEN-12){instr[31]}}, instr[31:20]};
          w_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        w_b     = {instr[31:12], 12'b0};
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_a     = pc;
        w_b     = {instr[31:12], 12'b0};
        w_legal = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign control   = w_legal ? w_ctl : CTL_ADD;
  assign operand_a = w_legal ? w_a : '0;
  assign operand_b = w_legal ? w_b : '0;
  assign rd        = instr[11:7];
  assign illegal   = ~w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decoded ALU op issue register with 2-entry skid and issue counter
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  operand_a,
  output logic [XLEN-1:0]  operand_b,
  output logic [3:0]       control,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  issue_entry_t     w_dec;
  issue_entry_t     r_out;
  issue_entry_t     r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_issue_count;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_out_free;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .instr     (instr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .pc        (pc),
    .control   (w_dec.control),
    .operand_a (w_dec.operand_a),
    .operand_b (w_dec.operand_b),
    .rd        (w_dec.rd),
    .illegal   (w_dec.illegal)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // the skid only fills while the output is stalled, so a full skid implies a valid output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out         <= '0;
      r_skid        <= '0;
      r_out_valid   <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_in_ready    <= 1'b1;
      r_issue_count <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_in_xfer) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
      if (w_out_xfer) begin
        r_issue_count <= r_issue_count + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign control     = r_out.control;
  assign operand_a   = r_out.operand_a;
  assign operand_b   = r_out.operand_b;
  assign rd          = r_out.rd;
  assign illegal     = r_out.illegal;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed checks of alu_issue_stage against a queue model
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  control;
  logic [4:0]  rd;
  logic        illegal;
  logic [31:0] issue_count;

  int          checks = 0;
  int          errors = 0;
  ent_t        mq[$];
  logic [31:0] mcnt = '0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .control     (control),
    .rd          (rd),
    .illegal     (illegal),
    .issue_count (issue_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] p);
    logic [3:0] tbl [8];
    ent_t       e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    tbl = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b0110, 4'b1010, 4'b0100, 4'b0010};
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ok  = 1'b0;
    e.ctl = 4'b0000; e.a = 0; e.b = 0; e.rd = ins[11:7]; e.ill = 1'b0;
    if (op == 7'b0110011) begin
      e.a = r1; e.b = r2;
      if (f7 == 7'd0) begin ok = 1'b1; e.ctl = tbl[f3]; end
      else if (f7 == 7'b0100000 && f3 == 3'd0) begin ok = 1'b1; e.ctl = 4'b0001; end
    end else if (op == 7'b0010011) begin
      e.a = r1; e.ctl = tbl[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin ok = (f7 == 7'd0); e.b = 32'(ins[24:20]); end
      else begin ok = 1'b1; e.b = 32'($signed(ins[31:20])); end
    end else if (op == 7'b0110111) begin
      ok = 1'b1; e.b = ins[31:12] << 12;
    end else if (op == 7'b0010111) begin
      ok = 1'b1; e.a = p; e.b = ins[31:12] << 12;
    end
    if (!ok) begin e.ctl = 4'b0000; e.a = 0; e.b = 0; e.ill = 1'b1; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6];
    logic [6:0] f7;
    int         k;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011, 7'b1100011};
    k   = $urandom_range(0, 5);
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'd0;
      2:       f7 = 7'b0100000;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), ops[k]};
  endfunction

  task automatic compare();
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("issue_count", issue_count, mcnt);
    if (mq.size() > 0) begin
      check("control", control, mq[0].ctl);
      check("operand_a", operand_a, mq[0].a);
      check("operand_b", operand_b, mq[0].b);
      check("rd", rd, mq[0].rd);
      check("illegal", illegal, mq[0].ill);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] p, input logic ordy,
                      input logic do_rst);
    logic exp_ready;
    rst = do_rst; in_valid = iv; instr = ins; rs1_data = r1; rs2_data = r2; pc = p;
    out_ready = ordy;
    if (do_rst) begin
      mq.delete();
      mcnt = '0;
    end else begin
      exp_ready = (mq.size() < 2);
      if (mq.size() > 0 && ordy) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (iv && exp_ready) mq.push_back(ref_decode(ins, r1, r2, p));
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'hFFFF_FFFF, 1, 2, 3, 1, 1);
    check("rst_operand_a", operand_a, 0);
    check("rst_operand_b", operand_b, 0);
    check("rst_control", control, 0);
    check("rst_rd", rd, 0);
    check("rst_illegal", illegal, 0);

    // SUB x3,x1,x2
    step(1, {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 5, 7, 0, 1, 0);
    check("sub_ctl", control, 4'b0001);
    check("sub_a", operand_a, 5);
    check("sub_b", operand_b, 7);
    check("sub_rd", rd, 3);
    // ADDI x1,x2,-1
    step(1, {12'hFFF, 5'd2, 3'b000, 5'd1, 7'b0010011}, 32'h10, 0, 0, 1, 0);
    check("sub_count", issue_count, 1);
    check("addi_b", operand_b, 32'hFFFF_FFFF);
    // SLLI shamt 31
    step(1, {7'd0, 5'd31, 5'd4, 3'b001, 5'd6, 7'b0010011}, 9, 0, 0, 1, 0);
    check("slli_ctl", control, 4'b1000);
    check("slli_b", operand_b, 32'h1F);
    step(1, {20'hABCDE, 5'd7, 7'b0110111}, 9, 9, 0, 1, 0);
    check("lui_a", operand_a, 0);
    check("lui_b", operand_b, 32'hABCDE000);
    step(1, {20'h00001, 5'd8, 7'b0010111}, 9, 9, 32'h100, 1, 0);
    check("auipc_a", operand_a, 32'h100);
    check("auipc_b", operand_b, 32'h1000);
    // SRA and a load opcode are both illegal
    step(1, {7'b0100000, 5'd2, 5'd1, 3'b101, 5'd9, 7'b0110011}, 5, 7, 0, 1, 0);
    check("sra_ill", illegal, 1);
    check("sra_rd", rd, 9);
    step(1, {12'h123, 5'd1, 3'b010, 5'd10, 7'b0000011}, 5, 7, 0, 1, 0);
    check("load_ill", illegal, 1);
    check("load_a", operand_a, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("ill_count", issue_count, 7);

    // backpressure: three cycles of stall with continuous input
    for (int i = 0; i < 3; i++) step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0);
    check("bp_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) step(1, rand_instr(), $urandom, $urandom, $urandom, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           ($urandom_range(0, 2) != 0), 0);
    end
    for (int i = 0; i < 20; i++) step(1, rand_instr(), $urandom, $urandom, $urandom, 1, 0);

    // reset with both entries occupied
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0);
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0);
    check("full_before_rst", in_ready, 0);
    step(1, rand_instr(), $urandom, $urandom, $urandom, 1, 1);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_count", issue_count, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
